score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of point requesters.
REQ-002 The block SHALL have parameter NDIG, default 5, giving the number of BCD score digits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port add_req, input, NREQ bits: per-requester add request, held high until acked.
REQ-006 The block SHALL have port add_pts, input, NREQ*8 bits: per-requester points, 2 BCD digits; slice i is [8i+7:8i], valid while add_req[i] is high.
REQ-007 The block SHALL have port clear, input, 1 bit: a single-cycle pulse that zeroes the working score.
REQ-008 The block SHALL have port frame_start, input, 1 bit: a single-cycle pulse at the top of each VGA frame.
REQ-009 The block SHALL have port add_ack, output, NREQ bits: one-hot completion pulse.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 The block SHALL have port score_bcd, output, NDIG*4 bits: the frame-stable score for score_gen; digit 0 is the LSD.
REQ-012 The block SHALL have port hi_bcd, output, NDIG*4 bits: the high score.

Function
REQ-013 The FSM SHALL have the states IDLE, ADD and DONE. A 3-bit digit index idx SHALL be used only in ADD.
REQ-014 In IDLE, with any add_req bit high and clear low, the block SHALL grant one requester by round-robin.
- The winner is the first requesting index at or after pointer rr, searching cyclically.
- On that edge the block latches the grant index and add_pts of the winner, sets idx=0 and carry=0, and enters ADD.
REQ-015 Each ADD cycle SHALL process one digit:
- sum = score[idx] + p[idx] + carry, where p[idx] = 0 for idx >= 2.
- If sum > 9, write sum-10 and set carry=1; otherwise write sum and set carry=0.
- Increment idx.
REQ-016 When idx = NDIG-1 and the digit produces a carry-out, the working score SHALL saturate to all digits 9.
REQ-017 After the idx = NDIG-1 cycle the FSM SHALL enter DONE.
REQ-018 In DONE the block SHALL, for exactly one cycle:
- assert add_ack[grant];
- load hi_bcd with the working score if the working score > hi_bcd (unsigned 20-bit compare is valid for BCD);
- set rr = (grant+1) mod NREQ;
- return to IDLE.
REQ-019 Latency SHALL be as follows:
- add_ack appears in the cycle after the 5th edge following the grant edge.
- Minimum spacing between grants is 7 cycles.
- The requester deasserts add_req on the cycle after the ack.
REQ-020 score_bcd SHALL load from the working score only on an edge where frame_start=1, so the display never tears mid-frame.
REQ-021 If frame_start coincides with a digit write or with clear, score_bcd SHALL take the working-register value held before that edge.
REQ-022 clear=1 SHALL take priority in any state:
- zero the working score and return to IDLE;
- leave hi_bcd, rr and score_bcd unchanged.
REQ-023 A request aborted by clear SHALL NOT be acked; it remains pending and is served after clear.
REQ-024 rr SHALL advance only in DONE. A single persistent requester SHALL therefore be served back-to-back without starving others.
REQ-025 An add_pts digit above 9 is a protocol violation; the RTL need not handle it.

Reset
REQ-026 When rst_n=0 on a clock edge, the block SHALL set:
- state = IDLE, idx = 0, carry = 0, rr = 0;
- working score, score_bcd and hi_bcd = 0;
- add_ack = 0 and busy = 0.
REQ-027 Reset SHALL override clear and any in-flight add; a pending request is re-arbitrated after reset.

Structure
REQ-028 Package score_pkg SHALL hold NDIG_C, NREQ_C, BCD_W=4, the state enum type and the typedef bcd_score_t (NDIG×4 bits).
REQ-029 A sub-module bcd_digit_add SHALL be used, with inputs a[3:0], b[3:0], cin and outputs s[3:0], cout; it is purely combinational.

Verification
REQ-030 Single add: reset, req0 with pts=0x25 -> ack0 on the 7th cycle after req; score_bcd=00025 after the next frame_start.
REQ-031 Ripple carry: score=09999, add 0x01 -> 10000; then score=99990, add 0x15 -> saturates to 99999.
REQ-032 Arbitration: req0..3 all held with pts 1,2,3,4 -> acks in order 0,1,2,3; then req1 and req3 re-raised -> order 1 then 3; final score=00010+0x04 more.
REQ-033 Frame latch: frame_start on the same edge as the DONE write -> score_bcd keeps its old value; the next frame_start shows the new value.
REQ-034 Clear mid-ADD at idx=2 -> working score=0, no ack, the request is re-served and the final score equals pts; hi_bcd is retained.
REQ-035 High score: scores 00050 then clear then 00030 -> hi_bcd stays 00050; rst_n=0 mid-ADD -> all outputs 0.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score keeper.
package score_pkg;

  localparam int NDIG_C = 5;
  localparam int NREQ_C = 4;
  localparam int BCD_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  typedef logic [NDIG_C*BCD_W-1:0] bcd_score_t;

endpackage

// File: rtl/score_keeper_bcd_digit_add.sv
// Single BCD digit adder with decimal carry; purely combinational.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (sum > 5'd9) begin
      s    = 4'(sum - 5'd10);
      cout = 1'b1;
    end else begin
      s    = sum[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Round-robin BCD score accumulator: one digit per cycle, saturating at all 9s,
// with a frame-latched display copy and a persistent high score.
module score_keeper
  import score_pkg::*;
#(
  parameter int NREQ = NREQ_C,
  parameter int NDIG = NDIG_C
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         add_req,
  input  logic [NREQ*8-1:0]       add_pts,
  input  logic                    clear,
  input  logic                    frame_start,
  output logic [NREQ-1:0]         add_ack,
  output logic                    busy,
  output logic [NDIG*BCD_W-1:0]   score_bcd,
  output logic [NDIG*BCD_W-1:0]   hi_bcd
);

  localparam int SW = NDIG * BCD_W;
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nxt;
  logic [2:0]      idx;
  logic            carry;
  logic [GW-1:0]   rr, grant_q, winner;
  logic            found;
  logic [7:0]      pts_q, pts_sel;
  logic [SW-1:0]   work, hi_q, disp_q;
  logic [3:0]      a_dig, b_dig, s_dig;
  logic            cout;
  logic            last_dig;
  logic [GW:0]     cand;

  // Cyclic search starting at rr; cand carries one spare bit to handle the wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, rr} + (GW+1)'(off);
      if (cand >= (GW+1)'(NREQ)) cand = cand - (GW+1)'(NREQ);
      if (!found && add_req[cand[GW-1:0]]) begin
        found  = 1'b1;
        winner = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    pts_sel = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (winner == GW'(r)) pts_sel = add_pts[r*8 +: 8];
    end
  end

  always_comb begin
    a_dig = '0;
    for (int d = 0; d < NDIG; d++) begin
      if (idx == 3'(d)) a_dig = work[d*BCD_W +: BCD_W];
    end
    case (idx)
      3'd0:    b_dig = pts_q[3:0];
      3'd1:    b_dig = pts_q[7:4];
      default: b_dig = 4'd0;
    endcase
    last_dig = (idx == 3'(NDIG-1));
  end

  bcd_digit_add u_digit (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry),
    .s    (s_dig),
    .cout (cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ADD;
      ADD:     if (last_dig) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // A clear landing in DONE aborts the add, so the ack is masked as well.
  always_comb begin
    add_ack = '0;
    if (state == DONE && !clear) add_ack[grant_q] = 1'b1;
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      rr      <= '0;
      grant_q <= '0;
      pts_q   <= '0;
      work    <= '0;
      hi_q    <= '0;
      disp_q  <= '0;
    end else begin
      state <= state_nxt;
      if (frame_start) disp_q <= work;
      if (clear) begin
        work  <= '0;
        idx   <= '0;
        carry <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (found) begin
              grant_q <= winner;
              pts_q   <= pts_sel;
              idx     <= '0;
              carry   <= 1'b0;
            end
          end
          ADD: begin
            if (last_dig && cout) begin
              work <= {NDIG{4'h9}};
            end else begin
              for (int d = 0; d < NDIG; d++) begin
                if (idx == 3'(d)) work[d*BCD_W +: BCD_W] <= s_dig;
              end
            end
            carry <= cout;
            idx   <= idx + 3'd1;
          end
          DONE: begin
            if (work > hi_q) hi_q <= work;
            rr  <= (grant_q == GW'(NREQ-1)) ? '0 : grant_q + GW'(1);
            idx <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign score_bcd = disp_q;
  assign hi_bcd    = hi_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench: stimulus pushes expected acks (index and cycle) to a queue,
// a negedge monitor pops and compares; scores are checked after frame latches.
module tb_score_keeper;
  import score_pkg::*;

  localparam int NREQ = NREQ_C;
  localparam int NDIG = NDIG_C;

  typedef struct {
    logic [NREQ-1:0] ack;
    int              cyc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clear = 1'b0;
  logic                frame_start = 1'b0;
  logic [NREQ-1:0]     add_req = '0;
  logic [NREQ*8-1:0]   add_pts = '0;
  logic [NREQ-1:0]     add_ack;
  logic                busy;
  bcd_score_t          score_bcd, hi_bcd;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0;
  exp_t exp_q[$];
  exp_t mon_e;

  score_keeper #(.NREQ(NREQ), .NDIG(NDIG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .add_req     (add_req),
    .add_pts     (add_pts),
    .clear       (clear),
    .frame_start (frame_start),
    .add_ack     (add_ack),
    .busy        (busy),
    .score_bcd   (score_bcd),
    .hi_bcd      (hi_bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (add_ack != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack got %b want none", add_ack);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_index", 32'(add_ack), 32'(mon_e.ack));
        check("ack_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Requester model: each requester drops its line the cycle after its ack.
  task automatic wait_acks(input int budget);
    logic [NREQ-1:0] drop;
    int n;
    drop = '0;
    n = 0;
    while (add_req != '0 && n < budget) begin
      @(posedge clk); #1;
      n++;
      add_req = add_req & ~drop;
      drop = add_ack;
    end
    check("req_drained", 32'(add_req), 32'd0);
  endtask

  task automatic add_one(input int i, input logic [7:0] p);
    add_pts[i*8 +: 8] = p;
    exp_q.push_back('{ack: NREQ'(1) << i, cyc: cyc + 6});
    add_req[i] = 1'b1;
    wait_acks(20);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_score", 32'(score_bcd), 32'h0);
    check("rst_hi", 32'(hi_bcd), 32'h0);
    check("rst_ack", 32'(add_ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // Single add, ack on the 7th cycle counting the request cycle
    add_one(0, 8'h25);
    check("single_busy", 32'(busy), 32'h0);
    pulse_frame();
    check("single_score", 32'(score_bcd), 32'h00025);
    check("single_hi", 32'(hi_bcd), 32'h00025);

    // High score survives clear
    add_one(0, 8'h25);
    check("hi_50", 32'(hi_bcd), 32'h00050);
    pulse_clear();
    add_one(1, 8'h30);
    pulse_frame();
    check("score_30", 32'(score_bcd), 32'h00030);
    check("hi_kept_50", 32'(hi_bcd), 32'h00050);

    // Clear while idx=2: no ack for the aborted pass, re-served afterwards
    add_pts[23:16] = 8'h07;
    t0 = cyc;
    exp_q.push_back('{ack: 4'b0100, cyc: t0 + 10});
    add_req[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear_busy", 32'(busy), 32'h0);
    wait_acks(30);
    pulse_frame();
    check("clear_reserve_score", 32'(score_bcd), 32'h00007);
    check("clear_hi_kept", 32'(hi_bcd), 32'h00050);

    // Frame latch coinciding with a digit write takes the pre-edge value
    pulse_clear();
    pulse_frame();
    check("frame_zero", 32'(score_bcd), 32'h0);
    add_pts[7:0] = 8'h11;
    t0 = cyc;
    exp_q.push_back('{ack: 4'b0001, cyc: t0 + 6});
    add_req[0] = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    check("frame_vs_write", 32'(score_bcd), 32'h0);
    wait_acks(20);
    pulse_frame();
    check("frame_next", 32'(score_bcd), 32'h00011);

    // Reset mid-ADD clears everything; pending request re-arbitrated
    add_pts[7:0] = 8'h33;
    t0 = cyc;
    exp_q.push_back('{ack: 4'b0001, cyc: t0 + 10});
    add_req[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_score", 32'(score_bcd), 32'h0);
    check("midrst_hi", 32'(hi_bcd), 32'h0);
    check("midrst_ack", 32'(add_ack), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    wait_acks(30);
    check("rerun_hi", 32'(hi_bcd), 32'h00033);
    pulse_frame();
    check("rerun_score", 32'(score_bcd), 32'h00033);

    // Round-robin arbitration from rr=0
    do_reset();
    add_pts = {8'h04, 8'h03, 8'h02, 8'h01};
    t0 = cyc;
    exp_q.push_back('{ack: 4'b0001, cyc: t0 + 6});
    exp_q.push_back('{ack: 4'b0010, cyc: t0 + 13});
    exp_q.push_back('{ack: 4'b0100, cyc: t0 + 20});
    exp_q.push_back('{ack: 4'b1000, cyc: t0 + 27});
    add_req = 4'b1111;
    wait_acks(60);
    pulse_frame();
    check("arb_score_10", 32'(score_bcd), 32'h00010);
    add_pts = {8'h03, 8'h00, 8'h01, 8'h00};
    t0 = cyc;
    exp_q.push_back('{ack: 4'b0010, cyc: t0 + 6});
    exp_q.push_back('{ack: 4'b1000, cyc: t0 + 13});
    add_req = 4'b1010;
    wait_acks(40);
    pulse_frame();
    check("arb_score_14", 32'(score_bcd), 32'h00014);
    check("arb_hi_14", 32'(hi_bcd), 32'h00014);

    // Ripple carry and saturation
    pulse_clear();
    for (int k = 0; k < 101; k++) add_one(0, 8'h99);
    pulse_frame();
    check("ripple_09999", 32'(score_bcd), 32'h09999);
    add_one(0, 8'h01);
    pulse_frame();
    check("ripple_10000", 32'(score_bcd), 32'h10000);
    pulse_clear();
    for (int k = 0; k < 1010; k++) add_one(0, 8'h99);
    pulse_frame();
    check("ripple_99990", 32'(score_bcd), 32'h99990);
    add_one(0, 8'h15);
    check("sat_hi", 32'(hi_bcd), 32'h99999);

    // Frame coinciding with clear latches the pre-clear value
    clear = 1'b1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    frame_start = 1'b0;
    check("sat_score", 32'(score_bcd), 32'h99999);
    pulse_frame();
    check("after_clear_score", 32'(score_bcd), 32'h0);
    check("after_clear_hi", 32'(hi_bcd), 32'h99999);

    repeat (10) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
